// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-channel round-robin select arbiter.
// Holds the channel, select and counter widths, the arbiter state encoding,
// and a one-hot to binary index helper.
package mux_arb_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Binary index of a one-hot vector; an all-zero vector maps to index 0.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = idx | (oh[i] ? SEL_W'(i) : 2'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Searches mask starting at channel last+1 and wrapping modulo 4, so the
// channel named by last has the lowest priority. any is low for an empty mask.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  last,
   output logic [SEL_W-1:0]  idx,
   output logic              any
);

   logic [SEL_W-1:0] cand_s;

   // First set bit of mask in rotating order after last.
   always_comb begin
      idx    = 2'd0;
      any    = 1'b0;
      cand_s = last;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand_s = last + SEL_W'(k);
         if (mask[cand_s] && !any) begin
            idx = cand_s;
            any = 1'b1;
         end else begin
            idx = idx;
            any = any;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter_4ch.sv
// Registered round-robin arbiter for four requesters feeding a 4:1 data mux.
// sel[1] drives mux s0 and sel[0] drives mux s1. The owner is preempted after
// MAX_HOLD cycles when another channel is requesting.
// Optional build macro ARB_LOCK_EN adds a lock input that suppresses the
// timeout preemption while asserted.
module rr_sel_arbiter_4ch
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
`ifdef ARB_LOCK_EN
   input  logic              lock,
`endif
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  sel,
   output logic              valid,
   output logic [CNT_W-1:0]  hold_cnt
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   arb_state_t        state_r,    state_nxt_s;
   logic [NUM_CH-1:0] grant_r,    grant_nxt_s;
   logic [SEL_W-1:0]  sel_r,      sel_nxt_s;
   logic              valid_r,    valid_nxt_s;
   logic [CNT_W-1:0]  hold_cnt_r, hold_cnt_nxt_s;
   logic [SEL_W-1:0]  last_r,     last_nxt_s;

   logic [NUM_CH-1:0] others_s;
   logic              owner_req_s;
   logic              lock_s;
   logic [SEL_W-1:0]  full_idx_s, oth_idx_s;
   logic              full_any_s, oth_any_s;

`ifdef ARB_LOCK_EN
   assign lock_s = lock;
`else
   assign lock_s = 1'b0;
`endif

   // While granted, sel_r names the current owner.
   assign owner_req_s = req[sel_r];
   assign others_s    = req & ~(4'b0001 << sel_r);

   // Fresh pick from idle rotates after the last owner.
   rr_pick u_pick_full (
      .mask (req),
      .last (last_r),
      .idx  (full_idx_s),
      .any  (full_any_s)
   );

   // Handoff pick rotates after the current owner, which becomes the new last.
   rr_pick u_pick_oth (
      .mask (others_s),
      .last (sel_r),
      .idx  (oth_idx_s),
      .any  (oth_any_s)
   );

   // Next-state, next-grant, pointer and hold-counter decisions.
   always_comb begin
      state_nxt_s    = state_r;
      grant_nxt_s    = grant_r;
      hold_cnt_nxt_s = hold_cnt_r;
      last_nxt_s     = last_r;
      case (state_r)
         IDLE: begin
            hold_cnt_nxt_s = 8'd0;
            if (full_any_s) begin
               state_nxt_s = GRANT;
               grant_nxt_s = 4'b0001 << full_idx_s;
            end else begin
               state_nxt_s = IDLE;
               grant_nxt_s = 4'b0000;
            end
         end
         GRANT: begin
            if (!owner_req_s) begin
               // Owner released: hand off without a bubble, or go idle.
               last_nxt_s     = sel_r;
               hold_cnt_nxt_s = 8'd0;
               if (oth_any_s) begin
                  grant_nxt_s = 4'b0001 << oth_idx_s;
               end else begin
                  state_nxt_s = IDLE;
                  grant_nxt_s = 4'b0000;
               end
            end else if (oth_any_s && (hold_cnt_r >= HOLD_LIM) && !lock_s) begin
               // Contested owner has used its window: preempt.
               last_nxt_s     = sel_r;
               hold_cnt_nxt_s = 8'd0;
               grant_nxt_s    = 4'b0001 << oth_idx_s;
            end else begin
               hold_cnt_nxt_s = (hold_cnt_r == CNT_MAX) ? CNT_MAX : hold_cnt_r + 8'd1;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            grant_nxt_s    = 4'b0000;
            hold_cnt_nxt_s = 8'd0;
         end
      endcase
      sel_nxt_s   = onehot_to_idx(grant_nxt_s);
      valid_nxt_s = |grant_nxt_s;
   end

   // State, registered outputs and last-owner pointer with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         grant_r    <= 4'b0000;
         sel_r      <= 2'd0;
         valid_r    <= 1'b0;
         hold_cnt_r <= 8'd0;
         last_r     <= 2'd3;
      end else begin
         state_r    <= state_nxt_s;
         grant_r    <= grant_nxt_s;
         sel_r      <= sel_nxt_s;
         valid_r    <= valid_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
         last_r     <= last_nxt_s;
      end
   end

   assign grant    = grant_r;
   assign sel      = sel_r;
   assign valid    = valid_r;
   assign hold_cnt = hold_cnt_r;

endmodule

// File: tb/tb_rr_sel_arbiter_4ch.sv
// Directed self-checking bench for rr_sel_arbiter_4ch with MAX_HOLD=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// The lock scenario is compiled in only when ARB_LOCK_EN is defined.
module tb_rr_sel_arbiter_4ch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
`ifdef ARB_LOCK_EN
   logic       lock;
`endif
   logic [3:0] grant;
   logic [1:0] sel;
   logic       valid;
   logic [7:0] hold_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   rr_sel_arbiter_4ch #(.MAX_HOLD(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
`ifdef ARB_LOCK_EN
      .lock     (lock),
`endif
      .grant    (grant),
      .sel      (sel),
      .valid    (valid),
      .hold_cnt (hold_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one edge, then check the one-hot invariant.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones(grant) <= 1), 32'd1);
   endtask

   task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] s);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_sel"},   32'(sel),   32'(s));
      chk({tag, "_valid"}, 32'(valid), 32'(g != 4'b0000));
   endtask

   logic [3:0] rot_req [4] = '{4'b1111, 4'b1011, 4'b0011, 4'b0010};
   logic [1:0] rot_exp [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
`ifdef ARB_LOCK_EN
      lock  = 1'b0;
`endif
      // Reset held two cycles with all requests high.
      tick();
      chk("rst1_grant", 32'(grant), 32'd0);
      tick();
      chk_grant("rst2", 4'b0000, 2'd0);
      chk("rst2_hold", 32'(hold_cnt), 32'd0);
      rst_n = 1'b1;
      tick();
      chk_grant("first", 4'b0001, 2'd0);
      chk("first_hold", 32'(hold_cnt), 32'd0);

      // Release handoff: ch0 -> ch2 with no idle cycle.
      req = 4'b0101;
      tick();
      chk_grant("keep0", 4'b0001, 2'd0);
      chk("keep0_hold", 32'(hold_cnt), 32'd1);
      req = 4'b0100;
      tick();
      chk_grant("handoff", 4'b0100, 2'd2);
      chk("handoff_hold", 32'(hold_cnt), 32'd0);
      req = 4'b0000;
      tick();
      chk_grant("idle1", 4'b0000, 2'd0);

      // Timeout fairness: last=2, so ch0 first, then 8-cycle alternation.
      req = 4'b0011;
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 8; k++) begin
            tick();
            chk("tmo_grant", 32'(grant), (w % 2 == 0) ? 32'd1 : 32'd2);
            chk("tmo_hold", 32'(hold_cnt), 32'(k));
         end
      end
      req = 4'b0000;
      tick();
      chk_grant("idle2", 4'b0000, 2'd0);

      // Uncontested hold on ch2, then ch3 appears past the limit.
      req = 4'b0100;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("unc_grant", 32'(grant), 32'd4);
         chk("unc_hold", 32'(hold_cnt), 32'(k));
      end
      req = 4'b1100;
      tick();
      chk_grant("late_comp", 4'b1000, 2'd3);
      chk("late_comp_hold", 32'(hold_cnt), 32'd0);
      req = 4'b0000;
      tick();
      chk_grant("idle3", 4'b0000, 2'd0);

      // Make ch1 the last owner, then rotate through all four channels.
      req = 4'b0010;
      tick();
      chk_grant("set_last1", 4'b0010, 2'd1);
      req = 4'b0000;
      tick();
      chk_grant("idle4", 4'b0000, 2'd0);
      for (int i = 0; i < 4; i++) begin
         req = rot_req[i];
         tick();
         chk_grant("rot", 4'b0001 << rot_exp[i], rot_exp[i]);
      end
      req = 4'b0000;
      tick();
      chk_grant("idle5", 4'b0000, 2'd0);

      // Reset mid-grant drops the grant on the sampling edge.
      req = 4'b0001;
      tick();
      chk_grant("pre_rst", 4'b0001, 2'd0);
      rst_n = 1'b0;
      tick();
      chk_grant("mid_rst", 4'b0000, 2'd0);
      chk("mid_rst_hold", 32'(hold_cnt), 32'd0);
      rst_n = 1'b1;
      req   = 4'b0000;
      tick();
      chk_grant("post_rst", 4'b0000, 2'd0);

`ifdef ARB_LOCK_EN
      // Lock suppresses the timeout well past MAX_HOLD.
      lock = 1'b1;
      req  = 4'b0011;
      for (int k = 0; k < 38; k++) begin
         tick();
         chk("lock_grant", 32'(grant), 32'd1);
         chk("lock_hold", 32'(hold_cnt), 32'(k));
      end
      req = 4'b0010;
      tick();
      chk_grant("lock_rel", 4'b0010, 2'd1);
      lock = 1'b0;
      req  = 4'b0000;
      tick();
      chk_grant("lock_idle", 4'b0000, 2'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_sel_arbiter_4ch.md
Name: rr_sel_arbiter_4ch

Overview:
- Registered round-robin arbiter for four requesters. It sits directly upstream of the 4:1 decoder-based data mux.
- It drives the mux select pair (s0, s1) from sel and provides a one-hot grant for the requesters.
- Guarantees a single stable select per ownership window, fair rotation, and a bounded hold time when other channels are contending.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one channel keeps the grant while another channel is requesting. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  4  request per channel; bit i = channel i
- grant  output  4  one-hot registered grant; all zero when idle
- sel  output  2  binary index of the granted channel; sel[1] drives mux s0, sel[0] drives mux s1
- valid  output  1  high while any grant is asserted (equals OR of grant)
- hold_cnt  output  8  cycles elapsed in the current ownership window (debug/visibility)

Behaviour:
- One clock, rst_n synchronous active-low. All state is sampled on the rising edge of clk.
- Reset values (rst_n low at an edge):
  - grant=0, sel=0, valid=0, hold_cnt=0, state=IDLE.
  - Last-owner pointer = 3, so channel 0 has highest priority after reset.
- Reset mid-grant: grant drops on the same edge that samples rst_n low. No partial window survives.
- Rotation pick: first set bit of the candidate mask, searched in order last+1, last+2, ... (mod 4).
- State IDLE (grant=0):
  - If req is nonzero, pick with the full req mask. Next edge: grant=onehot(pick), sel=pick, valid=1, hold_cnt=0, state=GRANT.
  - Latency from req to grant is exactly 1 cycle.
  - If req is zero, stay in IDLE.
- State GRANT, owner c. Let others = req with bit c cleared.
  - Release (req[c]=0):
    - If others is nonzero, switch to the pick of others on the same edge. No idle bubble; hold_cnt=0.
    - If others is zero, go to IDLE; grant=0, valid=0, hold_cnt=0.
  - Timeout (req[c]=1, hold_cnt==MAX_HOLD-1, others nonzero): switch to the pick of others; hold_cnt=0. A contested owner therefore holds for exactly MAX_HOLD cycles.
  - Otherwise, keep c. hold_cnt increments and saturates at 255.
  - If the owner is uncontested at timeout, it keeps the grant and hold_cnt keeps counting. If a competitor then appears while hold_cnt >= MAX_HOLD-1, switch on the next edge.
- Pointer update: last := c on every edge where ownership leaves c (release or timeout).
- sel and grant always change on the same edge. grant has at most one bit set (one-hot invariant).
- When the granted channel changes, the old and new grants are never high in the same cycle.

Optional Feature:
- Macro: ARB_LOCK_EN
- With ARB_LOCK_EN defined:
  - Adds input port lock (1 bit), placed after req.
  - While grant is nonzero and lock=1, the timeout switch is suppressed; the owner keeps the grant until req[c]=0.
  - hold_cnt still counts and saturates.
  - lock is ignored in IDLE.
- Without ARB_LOCK_EN: no lock port; the timeout rule always applies.

Decomposition:
- Package mux_arb_pkg:
  - NUM_CH=4, SEL_W=2, CNT_W=8.
  - typedef enum {IDLE, GRANT} arb_state_t.
  - Function onehot_to_idx.
- Sub-module rr_pick (combinational):
  - Inputs: mask[3:0], last[1:0].
  - Outputs: idx[1:0], any.
  - Instantiated once for the full req mask and once for others, or shared via a mask mux.
- Top level holds the FSM, pointer, and hold counter.

Test Plan:
- Reset/first grant: hold rst_n low for 2 cycles with req=4'b1111, then release. grant=0 during reset; one cycle after release, grant=4'b0001, sel=0, valid=1.
- Release handoff: ch0 owns, req=4'b0101. Drop req[0]. Next edge: grant=4'b0100, sel=2, valid stays 1 with no zero cycle.
- Timeout fairness, MAX_HOLD=8: req=4'b0011 held constant from idle. ch0 granted for exactly 8 cycles, then ch1 for 8, alternating. hold_cnt reads 0..7 in each window.
- Uncontested hold: only req[2] high for 20 cycles. grant=4'b0100 throughout; hold_cnt reaches 19. Raise req[3]: next edge grant=4'b1000.
- Rotation order: last owner=1, all req high after idle, then the owner drops each time it is granted. Grant sequence is ch2, ch3, ch0, ch1; one-hot checked every cycle.
- ARB_LOCK_EN build: lock=1 with req=4'b0011. ch0 keeps the grant for 30 cycles past MAX_HOLD. Drop req[0]: next edge grant=4'b0010.
